// File: rtl/diff_signature_collector_if.sv
// Handshake bundle for diff_signature_collector: difference-word input stream and signature output stream.
// Both streams use valid/ready: a transfer happens on the rising edge where valid && ready are both high.
interface diff_signature_collector_if #(
  parameter int DW = 27
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_diff;
  logic          sig_valid;
  logic          sig_ready;
  logic [31:0]   sig_data;

  modport master (
    output in_valid, in_diff, sig_ready,
    input  in_ready, sig_valid, sig_data
  );

  modport slave (
    input  in_valid, in_diff, sig_ready,
    output in_ready, sig_valid, sig_data
  );
endinterface

// File: rtl/diff_signature_collector.sv
// Buffers difference words in a small FIFO and folds each WINDOW-sample group into a 32-bit MISR signature.
// Optional feature: define DIFF_ABS_EN to fold |diff| instead of the raw two's-complement pattern.
module diff_signature_collector #(
  parameter int          DW     = 27,
  parameter int          DEPTH  = 4,
  parameter int          WINDOW = 16,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic                    clkin_data,
  input  logic                    rst_n,
  diff_signature_collector_if.slave bus,
  output logic [31:0]             probe_data
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [7:0]  WIN_LAST = 8'(WINDOW - 1);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   misr;
  logic [7:0]    sample_cnt;
  logic [15:0]   win_cnt;
  state_t        state;
  logic          sig_valid_q;
  logic [31:0]   sig_data_q;

  logic          push;
  logic          pop;
  logic [DW-1:0] head;
  logic [DW-1:0] head_val;
  logic [31:0]   misr_fold;

  // in_ready depends only on registered count, so a full FIFO refuses a push even when popping.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = (state == COLLECT) && (count != '0);
  assign head          = mem[rd_ptr];

`ifdef DIFF_ABS_EN
  // Negation wraps, so the most-negative word maps to itself.
  assign head_val = head[DW-1] ? (~head + DW'(1)) : head;
`else
  assign head_val = head;
`endif

  assign misr_fold = {misr[30:0], 1'b0} ^ (misr[31] ? POLY : 32'h0) ^ 32'(head_val);

  assign bus.sig_valid = sig_valid_q;
  assign bus.sig_data  = sig_data_q;
  assign probe_data    = {win_cnt, sample_cnt, 4'(count), 3'b000, state == PRESENT};

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge clkin_data) begin
    if (push) mem[wr_ptr] <= bus.in_diff;
  end

  always_ff @(posedge clkin_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      misr        <= SEED;
      sample_cnt  <= '0;
      win_cnt     <= '0;
      state       <= COLLECT;
      sig_valid_q <= 1'b0;
      sig_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        COLLECT: begin
          if (pop) begin
            misr <= misr_fold;
            if (sample_cnt == WIN_LAST) begin
              sig_data_q  <= misr_fold;
              sig_valid_q <= 1'b1;
              sample_cnt  <= '0;
              state       <= PRESENT;
            end else begin
              sample_cnt <= sample_cnt + 8'd1;
            end
          end
        end
        PRESENT: begin
          // sig_valid is always high here; the window closes only on a completed transfer.
          if (bus.sig_ready) begin
            sig_valid_q <= 1'b0;
            misr        <= SEED;
            win_cnt     <= win_cnt + 16'd1;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_diff_signature_collector.sv
// Directed bench for diff_signature_collector: two instances (SEED=0/WINDOW=1 and SEED=default/WINDOW=2)
// with per-instance expected queues checked by negedge monitors on each signature transfer.
module tb_diff_signature_collector;
  logic        clk;
  logic        rst_n;
  logic [31:0] probe_a;
  logic [31:0] probe_b;

  int total = 0;
  int bad   = 0;
  int hs_a  = 0;
  int hs_b  = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  diff_signature_collector_if #(.DW(27)) if_a ();
  diff_signature_collector_if #(.DW(27)) if_b ();

  diff_signature_collector #(.DW(27), .DEPTH(4), .WINDOW(1), .SEED(32'h0)) dut_a (
    .clkin_data(clk), .rst_n(rst_n), .bus(if_a.slave), .probe_data(probe_a)
  );

  diff_signature_collector #(.DW(27), .DEPTH(4), .WINDOW(2)) dut_b (
    .clkin_data(clk), .rst_n(rst_n), .bus(if_b.slave), .probe_data(probe_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitors: a transfer completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && if_a.sig_valid && if_a.sig_ready) begin
      hs_a++;
      if (exp_a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected: got %h expected none", if_a.sig_data);
      end else begin
        check("a_sig", if_a.sig_data, exp_a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_b.sig_valid && if_b.sig_ready) begin
      hs_b++;
      if (exp_b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got %h expected none", if_b.sig_data);
      end else begin
        check("b_sig", if_b.sig_data, exp_b_q.pop_front());
      end
    end
  end

  // driver tasks: called just after a rising edge
  task automatic push(input int which, input logic [26:0] v);
    int guard = 0;
    if (which == 0) begin if_a.in_valid = 1'b1; if_a.in_diff = v; end
    else            begin if_b.in_valid = 1'b1; if_b.in_diff = v; end
    @(negedge clk);
    while (!(which == 0 ? if_a.in_ready : if_b.in_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 (dut %0d)", which);
    end
    @(posedge clk); #1;
    if (which == 0) if_a.in_valid = 1'b0;
    else            if_b.in_valid = 1'b0;
  endtask

  task automatic drain(input int which);
    int guard = 0;
    while ((which == 0 ? exp_a_q.size() : exp_b_q.size()) != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 300) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending signatures expected none (dut %0d)", which);
    end
    @(posedge clk); #1;
  endtask

  logic [26:0] t2_v   [4];
  logic [31:0] t2_exp [4];
  logic [26:0] nxt;
  int          accepted;
  int          hs_base;

  initial begin
    t2_v = '{27'h7FFFFFF, 27'h7FFFFFB, 27'h4000000, 27'h0000123};
`ifdef DIFF_ABS_EN
    t2_exp = '{32'h00000001, 32'h00000005, 32'h04000000, 32'h00000123};
`else
    t2_exp = '{32'h07FFFFFF, 32'h07FFFFFB, 32'h04000000, 32'h00000123};
`endif

    rst_n = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_diff = '0; if_a.sig_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_diff = '0; if_b.sig_ready = 1'b1;
    #1;
    check("rst_a_in_ready",  32'(if_a.in_ready),  32'd1);
    check("rst_a_sig_valid", 32'(if_a.sig_valid), 32'd0);
    check("rst_a_sig_data",  if_a.sig_data,       32'd0);
    check("rst_a_probe",     probe_a,             32'd0);
    check("rst_b_probe",     probe_b,             32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single-word windows and latency
    exp_a_q.push_back(32'h00000001);
    push(0, 27'h1);
    @(negedge clk);
    check("lat_early", 32'(if_a.sig_valid), 32'd0);
    @(negedge clk);
    check("lat_on", 32'(if_a.sig_valid), 32'd1);
    @(posedge clk); #1;
    exp_a_q.push_back(32'h00000002);
    push(0, 27'h2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("win_cnt_2", 32'(probe_a[31:16]), 32'd2);
    @(posedge clk); #1;

    // sign handling of the folded word
    for (int i = 0; i < 4; i++) begin
      exp_a_q.push_back(t2_exp[i]);
      push(0, t2_v[i]);
    end
    drain(0);

    // backpressure: consumer stalled, producer always valid
    if_a.sig_ready = 1'b0;
    accepted = 0;
    nxt = 27'h10;
    if_a.in_valid = 1'b1;
    if_a.in_diff = nxt;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_a.in_ready) begin
        accepted++;
        exp_a_q.push_back(32'(nxt));
        @(posedge clk); #1;
        nxt = nxt + 27'd1;
        if_a.in_diff = nxt;
      end else begin
        @(posedge clk); #1;
      end
    end
    if_a.in_valid = 1'b0;
    check("accepted", 32'(accepted), 32'd5);
    @(negedge clk);
    check("full_in_ready", 32'(if_a.in_ready), 32'd0);
    check("full_count",    32'(probe_a[7:4]),  32'd4);
    check("full_state",    32'(probe_a[0]),    32'd1);
    repeat (3) @(negedge clk);
    check("stall_sig_data",  if_a.sig_data,       32'h00000010);
    check("stall_sig_valid", 32'(if_a.sig_valid), 32'd1);

    // one-cycle ready pulse, then drain the rest in order
    @(posedge clk); #1;
    hs_base = hs_a;
    if_a.sig_ready = 1'b1;
    @(posedge clk); #1;
    if_a.sig_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("after_pulse_count", 32'(probe_a[7:4]), 32'd3);
    check("after_pulse_data",  if_a.sig_data,     32'h00000011);
    @(posedge clk); #1;
    if_a.sig_ready = 1'b1;
    drain(0);
    check("drain_handshakes", 32'(hs_a - hs_base), 32'd5);

    // two-sample windows with the default seed (exercises the feedback path and reseeding)
    exp_b_q.push_back(32'hF2BCD926);
    push(1, 27'h1);
    push(1, 27'h1);
    exp_b_q.push_back(32'hF2BCD925);
    push(1, 27'h0);
    push(1, 27'h0);
    drain(1);
    check("b_win_cnt", 32'(probe_b[31:16]), 32'd2);

    // reset in the middle of a window
    push(1, 27'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("b_mid_sample_cnt", 32'(probe_b[15:8]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sig_valid", 32'(if_b.sig_valid), 32'd0);
    check("mid_rst_probe_b",   probe_b,             32'd0);
    check("mid_rst_probe_a",   probe_a,             32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_b_q.push_back(32'hF2BCD926);
    push(1, 27'h1);
    push(1, 27'h1);
    drain(1);
    check("b_win_cnt_after_rst", 32'(probe_b[31:16]), 32'd1);

    repeat (4) @(posedge clk);
    check("a_queue_left", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_left", 32'(exp_b_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
